cl_xor_axil_regs: RTL and testbench
===================================

// Module: cl_xor_axil_regs
// PURPOSE
//  AXI4-Lite slave register file for the XOR CL; consumes the master side of the OCL register slice.
//  Holds two operands and a registered A^B result, plus an XOR accumulator, a write counter and an ID.
//  Independent write (AW/W/B) and read (AR/R) channel FSMs; unmapped or illegal accesses return SLVERR.
// PARAMETERS
//  ADDR_W   32            width of awaddr/araddr; only bits [7:2] decoded, bits [1:0] ignored
//  BLK_ID   32'h0C15_0001 value returned at ID register
//  ERR_DATA 32'hDEAD_BEEF rdata returned on SLVERR reads
// PORTS
//  clk_main_a0   in   1       clock
//  rst_main      in   1       synchronous active-high reset
//  s_awaddr      in   ADDR_W  write address
//  s_awvalid     in   1       write address valid
//  s_awready     out  1       write address ready
//  s_wdata       in   32      write data
//  s_wstrb       in   4       byte strobes
//  s_wvalid      in   1       write data valid
//  s_wready      out  1       write data ready
//  s_bresp       out  2       write response (00 OKAY, 10 SLVERR)
//  s_bvalid      out  1       write response valid
//  s_bready      in   1       write response ready
//  s_araddr      in   ADDR_W  read address
//  s_arvalid     in   1       read address valid
//  s_arready     out  1       read address ready
//  s_rdata       out  32      read data
//  s_rresp       out  2       read response
//  s_rvalid      out  1       read data valid
//  s_rready      in   1       read data ready
// BEHAVIOUR
//  Map: 0x00 OPA RW | 0x04 OPB RW | 0x08 RESULT RO | 0x0C ACC RW | 0x10 ACC_XOR WO | 0x14 WCNT RO | 0x18 ID RO
//  Reset: all regs 0; all ready/valid outputs 0, bresp/rresp 00, rdata 0; readies rise the cycle after rst drops.
//  Reset mid-transaction: held AW/W/AR and pending B/R dropped, no register update; no response ever issued.
//  Write FSM W_ACCEPT/W_RESP: in W_ACCEPT awready=!aw_held, wready=!w_held; AW and W latch independently, any order.
//  Cycle with aw_held && w_held: commit, clear both held flags, go W_RESP, bvalid=1 from next cycle.
//  W_RESP: bvalid held with stable bresp until bready; on handshake return to W_ACCEPT (awready/wready re-rise next cycle).
//  Min write latency: AW+W same-cycle handshake at edge 0 -> commit edge 1 -> bvalid observed after edge 1.
//  OPA/OPB/ACC: byte lane i written only if wstrb[i]; wstrb=0 -> OKAY, no change, WCNT still increments.
//  ACC_XOR: ACC <= ACC ^ (wdata masked by wstrb lanes). Writing ACC loads it (masked).
//  RESULT <= OPA ^ OPB every cycle (one-cycle lag after OPA/OPB commit).
//  WCNT: +1 per OKAY write commit, 32-bit wrap 0xFFFF_FFFF -> 0; SLVERR writes do not count.
//  Writes to RO regs (0x08,0x14,0x18) or unmapped (>=0x1C) -> bresp=10, no state change.
//  Read FSM R_ACCEPT/R_RESP: arready=1 in R_ACCEPT; on AR handshake rdata/rresp captured from current regs, go R_RESP.
//  R_RESP: rvalid=1, rdata/rresp stable until rready; then R_ACCEPT. ACC_XOR reads SLVERR (WO).
//  Unmapped/WO read -> rresp=10, rdata=ERR_DATA.
//  Simultaneous read + write commit same cycle: read returns pre-commit value; channels never stall each other.
// TESTING
//  Reset, then read 0x18 -> rdata 0x0C15_0001, rresp 00; read 0x00 -> 0.
//  W before AW by 3 cycles: OPA=0xFFFF_0000, OPB=0x0F0F_0F0F -> both bresp 00; read 0x08 -> 0xF0F0_0F0F.
//  Write 0x0C=0x1234_5678, 0x10=0xFFFF_FFFF with wstrb=0011 -> read ACC = 0x1234_A987.
//  Write 0x08 and 0x40 -> bresp 10 each, RESULT unchanged, WCNT unchanged; read 0x40 -> 0xDEAD_BEEF, rresp 10.
//  Hold bready=0 for 5 cycles -> bvalid stays 1, awready/wready stay 0; rready=0 -> rdata stable.
//  Assert rst_main between AW and W handshakes -> no bvalid, OPA=0 after reset, next write completes normally.

Source files
------------

// File: rtl/cl_xor_axil_regs_if.sv
// AXI4-Lite register-slave bundle: AW/W/B write channels and AR/R read channels.
interface cl_xor_axil_regs_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/cl_xor_axil_regs.sv
// AXI4-Lite register file for the XOR CL: operands, registered XOR result,
// XOR accumulator, write counter and block ID, with independent write/read FSMs.
module cl_xor_axil_regs #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] BLK_ID   = 32'h0C15_0001,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input logic                clk_main_a0,
    input logic                rst_main,
    cl_xor_axil_regs_if.slave  s
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned IDX_W  = 6;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    localparam logic [IDX_W-1:0] IDX_OPA     = 6'd0;
    localparam logic [IDX_W-1:0] IDX_OPB     = 6'd1;
    localparam logic [IDX_W-1:0] IDX_RESULT  = 6'd2;
    localparam logic [IDX_W-1:0] IDX_ACC     = 6'd3;
    localparam logic [IDX_W-1:0] IDX_ACC_XOR = 6'd4;
    localparam logic [IDX_W-1:0] IDX_WCNT    = 6'd5;
    localparam logic [IDX_W-1:0] IDX_ID      = 6'd6;

    typedef enum logic {W_ACCEPT, W_RESP} wr_state_t;
    typedef enum logic {R_ACCEPT, R_RESP} rd_state_t;

    // Only address bits [7:2] select a register; the rest are deliberately ignored.
    logic unused_addr_bits_c;
    assign unused_addr_bits_c = ^{s.awaddr[ADDR_W-1:8], s.awaddr[1:0],
                                  s.araddr[ADDR_W-1:8], s.araddr[1:0]};

    // Register file
    logic [DATA_W-1:0] opa_q, opb_q, result_q, acc_q, wcnt_q;

    // Write channel state
    wr_state_t         wr_state_q, wr_state_n;
    logic              aw_held_q, aw_held_n;
    logic              w_held_q, w_held_n;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              awready_q, awready_n;
    logic              wready_q, wready_n;
    logic              bvalid_q, bvalid_n;
    logic [RESP_W-1:0] bresp_q, bresp_n;
    logic              commit_c;
    logic              wr_ok_c;
    logic [DATA_W-1:0] wmask_c;

    // Read channel state
    rd_state_t         rd_state_q, rd_state_n;
    logic              arready_q, arready_n;
    logic              rvalid_q, rvalid_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic [RESP_W-1:0] rresp_q, rresp_n;
    logic [IDX_W-1:0]  rd_idx_c;
    logic [DATA_W-1:0] rd_data_c;
    logic [RESP_W-1:0] rd_resp_c;

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;

    // Expand byte strobes into a bit mask for the held write data.
    always_comb begin
        wmask_c = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            wmask_c[8*i +: 8] = {8{wstrb_q[i]}};
        end
    end

    // Only the RW operand/accumulator registers and the WO ACC_XOR port accept writes.
    always_comb begin
        wr_ok_c = 1'b0;
        case (aw_idx_q)
            IDX_OPA, IDX_OPB, IDX_ACC, IDX_ACC_XOR: wr_ok_c = 1'b1;
            default:                                wr_ok_c = 1'b0;
        endcase
    end

    // Write FSM next state and registered channel outputs.
    always_comb begin
        wr_state_n = wr_state_q;
        aw_held_n  = aw_held_q;
        w_held_n   = w_held_q;
        bvalid_n   = bvalid_q;
        bresp_n    = bresp_q;
        commit_c   = 1'b0;
        case (wr_state_q)
            W_ACCEPT: begin
                if (aw_held_q && w_held_q) begin
                    commit_c   = 1'b1;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                    wr_state_n = W_RESP;
                    bvalid_n   = 1'b1;
                    bresp_n    = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    if (s.awvalid && awready_q) aw_held_n = 1'b1;
                    if (s.wvalid && wready_q)   w_held_n  = 1'b1;
                end
            end
            W_RESP: begin
                if (s.bready) begin
                    wr_state_n = W_ACCEPT;
                    bvalid_n   = 1'b0;
                end
            end
            default: wr_state_n = W_ACCEPT;
        endcase
        awready_n = (wr_state_n == W_ACCEPT) && !aw_held_n;
        wready_n  = (wr_state_n == W_ACCEPT) && !w_held_n;
    end

    // Write FSM state, held AW/W payloads and B channel registers.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            wr_state_q <= W_ACCEPT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_n;
            aw_held_q  <= aw_held_n;
            w_held_q   <= w_held_n;
            awready_q  <= awready_n;
            wready_q   <= wready_n;
            bvalid_q   <= bvalid_n;
            bresp_q    <= bresp_n;
            if (s.awvalid && awready_q) aw_idx_q <= s.awaddr[7:2];
            if (s.wvalid && wready_q) begin
                wdata_q <= s.wdata;
                wstrb_q <= s.wstrb;
            end
        end
    end

    // Register file update on write commit; RESULT tracks OPA^OPB one cycle behind.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            acc_q    <= '0;
            wcnt_q   <= '0;
        end else begin
            result_q <= opa_q ^ opb_q;
            if (commit_c && wr_ok_c) begin
                wcnt_q <= wcnt_q + DATA_W'(1);
                case (aw_idx_q)
                    IDX_OPA:     opa_q <= (opa_q & ~wmask_c) | (wdata_q & wmask_c);
                    IDX_OPB:     opb_q <= (opb_q & ~wmask_c) | (wdata_q & wmask_c);
                    IDX_ACC:     acc_q <= (acc_q & ~wmask_c) | (wdata_q & wmask_c);
                    IDX_ACC_XOR: acc_q <= acc_q ^ (wdata_q & wmask_c);
                    default:     ;
                endcase
            end
        end
    end

    // Read decode from the live register values (pre-commit on a same-cycle write).
    assign rd_idx_c = s.araddr[7:2];
    always_comb begin
        rd_data_c = ERR_DATA;
        rd_resp_c = RESP_SLVERR;
        case (rd_idx_c)
            IDX_OPA:    begin rd_data_c = opa_q;    rd_resp_c = RESP_OKAY; end
            IDX_OPB:    begin rd_data_c = opb_q;    rd_resp_c = RESP_OKAY; end
            IDX_RESULT: begin rd_data_c = result_q; rd_resp_c = RESP_OKAY; end
            IDX_ACC:    begin rd_data_c = acc_q;    rd_resp_c = RESP_OKAY; end
            IDX_WCNT:   begin rd_data_c = wcnt_q;   rd_resp_c = RESP_OKAY; end
            IDX_ID:     begin rd_data_c = BLK_ID;   rd_resp_c = RESP_OKAY; end
            default:    ;
        endcase
    end

    // Read FSM next state and registered R channel outputs.
    always_comb begin
        rd_state_n = rd_state_q;
        rvalid_n   = rvalid_q;
        rdata_n    = rdata_q;
        rresp_n    = rresp_q;
        case (rd_state_q)
            R_ACCEPT: begin
                if (s.arvalid && arready_q) begin
                    rd_state_n = R_RESP;
                    rvalid_n   = 1'b1;
                    rdata_n    = rd_data_c;
                    rresp_n    = rd_resp_c;
                end
            end
            R_RESP: begin
                if (s.rready) begin
                    rd_state_n = R_ACCEPT;
                    rvalid_n   = 1'b0;
                end
            end
            default: rd_state_n = R_ACCEPT;
        endcase
        arready_n = (rd_state_n == R_ACCEPT);
    end

    // Read FSM state and R channel registers.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            rd_state_q <= R_ACCEPT;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_n;
            arready_q  <= arready_n;
            rvalid_q   <= rvalid_n;
            rdata_q    <= rdata_n;
            rresp_q    <= rresp_n;
        end
    end
endmodule

// File: tb/tb_cl_xor_axil_regs.sv
// Self-checking bench for cl_xor_axil_regs: directed register scenarios plus
// randomized traffic against a register-level model of the XOR register file.
module tb_cl_xor_axil_regs;
    localparam int TMO = 40;

    logic clk_main_a0 = 1'b0;
    logic rst_main    = 1'b1;

    cl_xor_axil_regs_if #(.ADDR_W(32)) bus ();

    cl_xor_axil_regs dut (
        .clk_main_a0 (clk_main_a0),
        .rst_main    (rst_main),
        .s           (bus.slave)
    );

    initial forever #5 clk_main_a0 = ~clk_main_a0;

    // Counters
    int checks = 0, errors = 0;
    int main_chk = 0, main_err = 0;
    int chk_seen = 0, err_seen = 0;

    // Expected responses, in issue order
    logic [1:0]  bq[$];
    logic [31:0] rq_d[$];
    logic [1:0]  rq_r[$];

    // Register model
    logic [31:0] m_opa = '0, m_opb = '0, m_acc = '0, m_wcnt = '0;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (strb[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
        logic [31:0] m;
        int unsigned reg_no;
        m = strb_mask(strb);
        reg_no = (a % 256) / 4;
        case (reg_no)
            0: m_opa = (m_opa & ~m) | (d & m);
            1: m_opb = (m_opb & ~m) | (d & m);
            3: m_acc = (m_acc & ~m) | (d & m);
            4: m_acc = m_acc ^ (d & m);
            default: return 2'b10;
        endcase
        m_wcnt = m_wcnt + 1;
        return 2'b00;
    endfunction

    task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int unsigned reg_no;
        reg_no = (a % 256) / 4;
        r = 2'b00;
        case (reg_no)
            0: d = m_opa;
            1: d = m_opb;
            2: d = m_opa ^ m_opb;
            3: d = m_acc;
            5: d = m_wcnt;
            6: d = 32'h0C15_0001;
            default: begin d = 32'hDEAD_BEEF; r = 2'b10; end
        endcase
    endtask

    // Reset history as seen at each rising edge
    logic rst_d = 1'b0, rst_d2 = 1'b0;
    initial forever begin
        @(posedge clk_main_a0);
        rst_d2 = rst_d;
        rst_d  = rst_main;
    end

    // Per-cycle compare process
    logic        b_hold = 1'b0, r_hold = 1'b0;
    logic [1:0]  b_prev, r_prev_r;
    logic [31:0] r_prev_d;
    initial forever begin
        @(negedge clk_main_a0);
        if (main_chk != chk_seen) begin checks = checks + (main_chk - chk_seen); chk_seen = main_chk; end
        if (main_err != err_seen) begin errors = errors + (main_err - err_seen); err_seen = main_err; end
        if (rst_d) begin
            checks++;
            if (bus.awready || bus.wready || bus.bvalid || bus.arready || bus.rvalid ||
                bus.bresp != 2'b00 || bus.rresp != 2'b00 || bus.rdata != 32'h0) begin
                errors++;
                $display("FAIL reset_outputs actual aw%b w%b b%b ar%b r%b bresp%b rresp%b rdata%h required all zero",
                         bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.bresp, bus.rresp, bus.rdata);
            end
            b_hold = 1'b0;
            r_hold = 1'b0;
        end else begin
            if (rst_d2) begin
                checks++;
                if (!(bus.awready && bus.wready && bus.arready) || bus.bvalid || bus.rvalid) begin
                    errors++;
                    $display("FAIL post_reset_ready actual aw%b w%b ar%b b%b r%b required 11100",
                             bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid);
                end
            end
            if (bus.bvalid) begin
                checks++;
                if (bus.awready || bus.wready) begin
                    errors++;
                    $display("FAIL ready_during_b actual aw%b w%b required 00", bus.awready, bus.wready);
                end
                if (b_hold) begin
                    checks++;
                    if (bus.bresp != b_prev) begin
                        errors++;
                        $display("FAIL bresp_stable actual %b required %b", bus.bresp, b_prev);
                    end
                end
                checks++;
                if (bq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bvalid actual 1 required 0");
                end else if (bus.bready) begin
                    logic [1:0] e;
                    e = bq.pop_front();
                    if (bus.bresp != e) begin
                        errors++;
                        $display("FAIL bresp actual %b required %b", bus.bresp, e);
                    end
                end
            end
            if (bus.rvalid) begin
                checks++;
                if (bus.arready) begin
                    errors++;
                    $display("FAIL arready_during_r actual 1 required 0");
                end
                if (r_hold) begin
                    checks++;
                    if (bus.rdata != r_prev_d || bus.rresp != r_prev_r) begin
                        errors++;
                        $display("FAIL r_stable actual %h/%b required %h/%b", bus.rdata, bus.rresp, r_prev_d, r_prev_r);
                    end
                end
                checks++;
                if (rq_d.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid actual 1 required 0");
                end else if (bus.rready) begin
                    logic [31:0] ed;
                    logic [1:0]  er;
                    ed = rq_d.pop_front();
                    er = rq_r.pop_front();
                    if (bus.rdata != ed || bus.rresp != er) begin
                        errors++;
                        $display("FAIL read_data actual %h/%b required %h/%b", bus.rdata, bus.rresp, ed, er);
                    end
                end
            end
            b_hold   = bus.bvalid && !bus.bready;
            b_prev   = bus.bresp;
            r_hold   = bus.rvalid && !bus.rready;
            r_prev_d = bus.rdata;
            r_prev_r = bus.rresp;
        end
    end

    task automatic timeout(input string what);
        main_chk++;
        main_err++;
        $display("FAIL timeout_%s actual %0d cycles required handshake", what, TMO);
    endtask

    task automatic send_aw(input logic [31:0] a, input int dly);
        repeat (dly) @(posedge clk_main_a0);
        #1;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_main_a0);
            if (bus.awready) begin
                @(posedge clk_main_a0);
                #1 bus.awvalid = 1'b0;
                return;
            end
        end
        bus.awvalid = 1'b0;
        timeout("aw");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input int dly);
        repeat (dly) @(posedge clk_main_a0);
        #1;
        bus.wdata  = d;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_main_a0);
            if (bus.wready) begin
                @(posedge clk_main_a0);
                #1 bus.wvalid = 1'b0;
                return;
            end
        end
        bus.wvalid = 1'b0;
        timeout("w");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit seen;
        bq.push_back(m_write(a, d, strb));
        fork
            send_aw(a, aw_dly);
            send_w(d, strb, w_dly);
        join
        seen = 1'b0;
        for (int i = 0; i < TMO && !seen; i++) begin
            @(negedge clk_main_a0);
            seen = bus.bvalid;
        end
        if (!seen) begin
            timeout("b");
            return;
        end
        @(posedge clk_main_a0);
        repeat (b_dly) @(posedge clk_main_a0);
        #1 bus.bready = 1'b1;
        @(posedge clk_main_a0);
        #1 bus.bready = 1'b0;
    endtask

    task automatic do_read_exp(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er, input int r_dly);
        bit seen;
        rq_d.push_back(ed);
        rq_r.push_back(er);
        #1;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < TMO && !seen; i++) begin
            @(negedge clk_main_a0);
            seen = bus.arready;
        end
        if (!seen) begin
            bus.arvalid = 1'b0;
            timeout("ar");
            return;
        end
        @(posedge clk_main_a0);
        #1 bus.arvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < TMO && !seen; i++) begin
            @(negedge clk_main_a0);
            seen = bus.rvalid;
        end
        if (!seen) begin
            timeout("r");
            return;
        end
        @(posedge clk_main_a0);
        repeat (r_dly) @(posedge clk_main_a0);
        #1 bus.rready = 1'b1;
        @(posedge clk_main_a0);
        #1 bus.rready = 1'b0;
    endtask

    // Read with a hand-computed expectation; also confirms the model agrees with it.
    task automatic read_lit(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er, input int r_dly);
        logic [31:0] md;
        logic [1:0]  mr;
        m_read(a, md, mr);
        main_chk++;
        if (md != ed || mr != er) begin
            main_err++;
            $display("FAIL model_pin addr %h actual %h/%b required %h/%b", a, md, mr, ed, er);
        end
        do_read_exp(a, ed, er, r_dly);
    endtask

    task automatic read_mdl(input logic [31:0] a, input int r_dly);
        logic [31:0] md;
        logic [1:0]  mr;
        m_read(a, md, mr);
        do_read_exp(a, md, mr, r_dly);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k <= 7) return 32'(k * 4) | 32'($urandom_range(0, 3));
        else if (k == 8) return 32'h40;
        return $urandom();
    endfunction

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) @(posedge clk_main_a0);
        #1 rst_main = 1'b0;
        @(posedge clk_main_a0);

        // ID and reset value
        read_lit(32'h18, 32'h0C15_0001, 2'b00, 0);
        read_lit(32'h00, 32'h0, 2'b00, 0);

        // W leads AW by three cycles
        do_write(32'h00, 32'hFFFF_0000, 4'hF, 3, 0, 0);
        do_write(32'h04, 32'h0F0F_0F0F, 4'hF, 3, 0, 0);
        read_lit(32'h08, 32'hF0F0_0F0F, 2'b00, 0);

        // Accumulator load then masked XOR
        do_write(32'h0C, 32'h1234_5678, 4'hF, 0, 0, 0);
        do_write(32'h10, 32'hFFFF_FFFF, 4'b0011, 0, 0, 0);
        read_lit(32'h0C, 32'h1234_A987, 2'b00, 0);

        // Illegal writes and reads
        do_write(32'h08, 32'h5555_5555, 4'hF, 0, 1, 0);
        do_write(32'h40, 32'h5555_5555, 4'hF, 1, 0, 0);
        read_lit(32'h08, 32'hF0F0_0F0F, 2'b00, 0);
        read_lit(32'h14, 32'd4, 2'b00, 0);
        read_lit(32'h40, 32'hDEAD_BEEF, 2'b10, 0);
        read_lit(32'h10, 32'hDEAD_BEEF, 2'b10, 0);

        // Zero strobes still count; back-pressure on B and R
        do_write(32'h00, 32'h1111_1111, 4'h0, 0, 0, 5);
        read_lit(32'h00, 32'hFFFF_0000, 2'b00, 5);
        read_lit(32'h14, 32'd5, 2'b00, 0);

        // Randomized traffic
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                read_mdl(rand_addr(), $urandom_range(0, 3));
        end

        // Reset between AW and W handshakes
        send_aw(32'h00, 0);
        rst_main = 1'b1;
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
        repeat (2) @(posedge clk_main_a0);
        #1 rst_main = 1'b0;
        m_opa = '0; m_opb = '0; m_acc = '0; m_wcnt = '0;
        repeat (6) @(posedge clk_main_a0);
        read_lit(32'h00, 32'h0, 2'b00, 0);
        do_write(32'h04, 32'hA5A5_5A5A, 4'hF, 0, 0, 0);
        read_lit(32'h04, 32'hA5A5_5A5A, 2'b00, 0);
        read_lit(32'h00, 32'h0, 2'b00, 0);
        read_lit(32'h14, 32'd1, 2'b00, 0);

        repeat (3) @(negedge clk_main_a0);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
